// File: rtl/dbg_pkg.sv
// Shared definitions for the UART debug command sequencer: host opcodes and FSM states.
// S_ECHO exists only when DBG_CMD_ECHO_EN is defined.
package dbg_pkg;

  localparam logic [7:0] CMD_DUMP_REGS = 8'h01;
  localparam logic [7:0] CMD_LOAD      = 8'h07;
  localparam logic [7:0] CMD_CONT      = 8'h08;
  localparam logic [7:0] CMD_STEP_MODE = 8'h09;
  localparam logic [7:0] CMD_STEP      = 8'h0A;
  localparam logic [7:0] CMD_START     = 8'h0D;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_CNT,
    S_LOAD_BYTE,
    S_WRITE,
    S_DUMP_REQ,
    S_DUMP_SEND,
    S_DUMP_WAIT
`ifdef DBG_CMD_ECHO_EN
    , S_ECHO
`endif
  } dbg_state_e;

  function automatic logic is_cmd(input logic [7:0] b);
    return b inside {CMD_DUMP_REGS, CMD_LOAD, CMD_CONT, CMD_STEP_MODE, CMD_STEP, CMD_START};
  endfunction

endpackage

// File: rtl/dbg_word_serializer.sv
// Sends the low byte_count bytes of a word LSB first over the tx_start/tx_done handshake
// and pulses word_done together with the final tx_done.
module dbg_word_serializer #(
  parameter int unsigned DATA_W = 32,
  localparam int unsigned CNT_W = $clog2(DATA_W / 8) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              load,
  input  logic [DATA_W-1:0] word,
  input  logic [CNT_W-1:0]  byte_count,
  input  logic              tx_done,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  output logic              word_done
);

  typedef enum logic {SER_IDLE, SER_WAIT} ser_state_e;

  ser_state_e        state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  left_q, left_d;
  logic [7:0]        data_q, data_d;
  logic              start_q, start_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= SER_IDLE;
      shift_q <= '0;
      left_q  <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      left_q  <= left_d;
      data_q  <= data_d;
      start_q <= start_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    left_d    = left_q;
    data_d    = data_q;
    start_d   = 1'b0;
    word_done = 1'b0;
    case (state_q)
      SER_IDLE: begin
        if (load) begin
          data_d  = word[7:0];
          shift_d = word >> 8;
          left_d  = byte_count - CNT_W'(1);
          start_d = 1'b1;
          state_d = SER_WAIT;
        end
      end
      SER_WAIT: begin
        // tx_data holds until tx_done; the next start lands in the following cycle
        if (tx_done) begin
          if (left_q == '0) begin
            word_done = 1'b1;
            state_d   = SER_IDLE;
          end else begin
            data_d  = shift_q[7:0];
            shift_d = shift_q >> 8;
            left_d  = left_q - CNT_W'(1);
            start_d = 1'b1;
          end
        end
      end
      default: state_d = SER_IDLE;
    endcase
  end

  assign tx_data  = data_q;
  assign tx_start = start_q;

endmodule

// File: rtl/dbg_cmd_sequencer.sv
// Host debug controller: program load, register dump and run/step control of the pipeline.
// Define DBG_CMD_ECHO_EN to echo each accepted command byte before acting on it.
module dbg_cmd_sequencer
  import dbg_pkg::*;
#(
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned MAX_INSTRUCTION = 64,
  parameter int unsigned NUM_REGISTERS   = 32
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [7:0]                       i_rx_data,
  input  logic                             i_rx_valid,
  output logic [7:0]                       o_tx_data,
  output logic                             o_tx_start,
  input  logic                             i_tx_done,
  output logic                             o_imem_we,
  output logic [ADDR_WIDTH-1:0]            o_imem_addr,
  output logic [DATA_W-1:0]                o_imem_data,
  output logic [$clog2(NUM_REGISTERS)-1:0] o_reg_addr,
  input  logic [DATA_W-1:0]                i_reg_data,
  input  logic                             i_halt,
  output logic                             o_cpu_stall,
  output logic                             o_cpu_restart
);

  localparam int unsigned REG_W  = $clog2(NUM_REGISTERS);
  localparam int unsigned IDX_W  = $clog2(MAX_INSTRUCTION + 1);
  localparam int unsigned BYTE_W = $clog2(DATA_W / 8);
  localparam int unsigned CNT_W  = BYTE_W + 1;

  dbg_state_e        state_q, state_d;
  logic              mode_q, mode_d;
  logic              running_q, running_d;
  logic              restart_q, restart_d;
  logic              step_q, step_d;
  logic [BYTE_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [IDX_W-1:0]  word_idx_q, word_idx_d;
  logic [IDX_W-1:0]  n_words_q, n_words_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [REG_W-1:0]  reg_idx_q, reg_idx_d;

  logic              exec;
  logic [7:0]        exec_cmd;
  logic              dump_load, dump_active;
  logic              ser_load, ser_done;
  logic [DATA_W-1:0] ser_word;
  logic [CNT_W-1:0]  ser_count;
  logic [31:0]       rx_ext;

  assign rx_ext      = 32'(i_rx_data);
  assign dump_load   = (state_q == S_DUMP_REQ);
  assign dump_active = state_q inside {S_DUMP_REQ, S_DUMP_SEND, S_DUMP_WAIT};

`ifdef DBG_CMD_ECHO_EN
  logic [7:0] cmd_q, cmd_d;
  logic       echo_load;

  assign echo_load = (state_q == S_IDLE) && i_rx_valid && is_cmd(i_rx_data);
  assign exec      = (state_q == S_ECHO) && ser_done;
  assign exec_cmd  = cmd_q;
  assign ser_load  = dump_load || echo_load;
  assign ser_word  = dump_load ? i_reg_data : DATA_W'(i_rx_data);
  assign ser_count = dump_load ? CNT_W'(DATA_W / 8) : CNT_W'(1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) cmd_q <= '0;
    else       cmd_q <= cmd_d;
  end

  always_comb begin
    cmd_d = cmd_q;
    if (echo_load) cmd_d = i_rx_data;
  end
`else
  assign exec      = (state_q == S_IDLE) && i_rx_valid;
  assign exec_cmd  = i_rx_data;
  assign ser_load  = dump_load;
  assign ser_word  = i_reg_data;
  assign ser_count = CNT_W'(DATA_W / 8);
`endif

  dbg_word_serializer #(
    .DATA_W (DATA_W)
  ) u_serializer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .load       (ser_load),
    .word       (ser_word),
    .byte_count (ser_count),
    .tx_done    (i_tx_done),
    .tx_data    (o_tx_data),
    .tx_start   (o_tx_start),
    .word_done  (ser_done)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      mode_q     <= 1'b0;
      running_q  <= 1'b0;
      restart_q  <= 1'b0;
      step_q     <= 1'b0;
      byte_cnt_q <= '0;
      word_idx_q <= '0;
      n_words_q  <= '0;
      word_q     <= '0;
      reg_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      running_q  <= running_d;
      restart_q  <= restart_d;
      step_q     <= step_d;
      byte_cnt_q <= byte_cnt_d;
      word_idx_q <= word_idx_d;
      n_words_q  <= n_words_d;
      word_q     <= word_d;
      reg_idx_q  <= reg_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    running_d  = running_q;
    restart_d  = 1'b0;
    step_d     = 1'b0;
    byte_cnt_d = byte_cnt_q;
    word_idx_d = word_idx_q;
    n_words_d  = n_words_q;
    word_d     = word_q;
    reg_idx_d  = reg_idx_q;
    if (i_halt) running_d = 1'b0;

    unique case (state_q)
`ifdef DBG_CMD_ECHO_EN
      S_IDLE: if (echo_load) state_d = S_ECHO;
      S_ECHO: ;
`else
      S_IDLE: ;
`endif
      S_LOAD_CNT: begin
        if (i_rx_valid) begin
          if (i_rx_data == 8'd0 || rx_ext > 32'(MAX_INSTRUCTION)) begin
            state_d = S_IDLE;
          end else begin
            n_words_d  = IDX_W'(i_rx_data);
            word_idx_d = '0;
            byte_cnt_d = '0;
            state_d    = S_LOAD_BYTE;
          end
        end
      end
      S_LOAD_BYTE: begin
        if (i_rx_valid) begin
          word_d     = {i_rx_data, word_q[DATA_W-1:8]};
          byte_cnt_d = byte_cnt_q + BYTE_W'(1);
          if (byte_cnt_q == BYTE_W'(DATA_W / 8 - 1)) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        word_idx_d = word_idx_q + IDX_W'(1);
        state_d    = (word_idx_q == n_words_q - IDX_W'(1)) ? S_IDLE : S_LOAD_BYTE;
      end
      S_DUMP_REQ:  state_d = S_DUMP_SEND;
      S_DUMP_SEND: state_d = S_DUMP_WAIT;
      S_DUMP_WAIT: begin
        if (i_tx_done) begin
          if (!ser_done) begin
            state_d = S_DUMP_SEND;
          end else if (reg_idx_q == REG_W'(NUM_REGISTERS - 1)) begin
            state_d = S_IDLE;
          end else begin
            reg_idx_d = reg_idx_q + REG_W'(1);
            state_d   = S_DUMP_REQ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (exec) begin
      state_d = S_IDLE;
      case (exec_cmd)
        CMD_DUMP_REGS: begin
          reg_idx_d = '0;
          state_d   = S_DUMP_REQ;
        end
        CMD_LOAD:      if (!running_q) state_d = S_LOAD_CNT;
        CMD_CONT:      if (!running_q) mode_d = 1'b0;
        CMD_STEP_MODE: if (!running_q) mode_d = 1'b1;
        // a halt in the same cycle wins over the step release
        CMD_STEP:      if (running_q && mode_q && !i_halt) step_d = 1'b1;
        CMD_START: begin
          restart_d = 1'b1;
          running_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_imem_we     = (state_q == S_WRITE);
  assign o_imem_addr   = ADDR_WIDTH'(word_idx_q) << 2;
  assign o_imem_data   = word_q;
  assign o_reg_addr    = reg_idx_q;
  assign o_cpu_restart = restart_q;
  assign o_cpu_stall   = !running_q || dump_active || (mode_q && !step_q);

endmodule

// File: doc/dbg_cmd_sequencer.md
# dbg_cmd_sequencer

UART-side debug controller between the byte-level UART receiver/transmitter pair and the MIPS pipeline. Decodes host command bytes, loads programs into instruction memory, sequences run control (continuous or single-step) through the pipeline stall input, and streams the register file back to the host.

## Interface
- DATA_W, 32, instruction/register word width
- ADDR_WIDTH, 32, instruction memory byte-address width
- MAX_INSTRUCTION, 64, maximum words per program load
- NUM_REGISTERS, 32, registers dumped by command 0x01
- i_clk  in  1  clock
- i_rst  in  1  reset: asynchronous, active-high
- i_rx_data  in  8  received byte, valid with i_rx_valid
- i_rx_valid  in  1  one-cycle pulse per received byte
- o_tx_data  out  8  byte to transmit
- o_tx_start  out  1  one-cycle pulse launching o_tx_data
- i_tx_done  in  1  one-cycle pulse when transmitter finishes a byte
- o_imem_we  out  1  instruction memory write strobe
- o_imem_addr  out  ADDR_WIDTH  byte address (word index << 2)
- o_imem_data  out  DATA_W  instruction word
- o_reg_addr  out  $clog2(NUM_REGISTERS)  register file debug read address (combinational read)
- i_reg_data  in  DATA_W  register file debug read data
- i_halt  in  1  pipeline reached end of program
- o_cpu_stall  out  1  1 freezes the pipeline
- o_cpu_restart  out  1  one-cycle pulse clearing the PC and pipeline latches

## Operation
- Commands (only while in S_IDLE): 0x01 dump registers; 0x07 load program; 0x08 select continuous mode; 0x09 select step mode; 0x0A step; 0x0D start. All other bytes ignored.
- Load: in S_LOAD_CNT, the next byte is N. N=0 or N>MAX_INSTRUCTION -> return to S_IDLE, no writes. Otherwise S_LOAD_BYTE collects 4·N bytes LSB first. After each 4th byte, S_WRITE writes the word at index k=0..N-1. 0x07 while running is ignored.
- Dump: for r=0..NUM_REGISTERS-1, S_DUMP_REQ drives o_reg_addr=r and captures i_reg_data one cycle later. S_DUMP_SEND emits 4 bytes LSB first, each followed by S_DUMP_WAIT for i_tx_done. Total 4·NUM_REGISTERS bytes, then S_IDLE.
- Run control: flags mode (0 continuous, 1 step) and running.
- 0x0D: pulses o_cpu_restart and sets running=1.
- Mode commands: 0x08/0x09 change mode only while running=0; otherwise ignored.
- Continuous: o_cpu_stall=0 while running.
- Step: o_cpu_stall=1 except for exactly one cycle after each accepted 0x0A. 0x0A is ignored if running=0 or mode=0.
- i_halt=1 clears running in either mode. This takes priority over a simultaneous step release.
- o_cpu_stall=1 whenever running=0 or state is in S_DUMP_*. A dump therefore freezes a continuous run and resumes it afterwards.
- Bytes received outside S_IDLE, S_LOAD_CNT or S_LOAD_BYTE are dropped. This includes all bytes received during a dump.

## Timing
- Reset values: state S_IDLE, mode=0, running=0, o_cpu_stall=1, o_cpu_restart=0, o_tx_start=0, o_tx_data=0, o_imem_we=0, o_imem_addr=0, o_imem_data=0, o_reg_addr=0.
- A command byte takes effect on the clock edge after its i_rx_valid cycle. o_cpu_restart and the step release occur in the cycle following that edge.
- o_imem_we is high for one cycle, one cycle after the valid of the 4th byte of the word. Address and data are stable in that same cycle.
- o_tx_start pulses once per byte, and o_tx_data is held until i_tx_done. The next o_tx_start comes no earlier than the cycle after i_tx_done.
- Register capture latency: 1 cycle from o_reg_addr change.
- Reset mid-load or mid-dump aborts immediately. Partial words are never written, and no further o_tx_start is issued.
- The word index counter does not wrap. The load terminates after word N-1.

## Configuration
- DBG_CMD_ECHO_EN defined: every accepted command byte in S_IDLE (0x01, 0x07, 0x08, 0x09, 0x0A, 0x0D) is first echoed on TX (state S_ECHO, wait for i_tx_done) before its action starts. Ignored bytes and load payload bytes are not echoed.
- Not defined: no echo; S_ECHO is absent; TX is used only by the dump.

## Structure
- Shared package dbg_pkg: command opcodes (CMD_DUMP_REGS=0x01, CMD_LOAD=0x07, CMD_CONT=0x08, CMD_STEP_MODE=0x09, CMD_STEP=0x0A, CMD_START=0x0D) and the state enumeration.
- One sub-module dbg_word_serializer: loads a DATA_W word, emits bytes LSB first with the o_tx_start/i_tx_done handshake, and signals word-done. Used by the dump and, under DBG_CMD_ECHO_EN, by the echo path with byte count 1.

## Test plan
- Load: 0x07, 0x02, bytes 01 01 01 3C, 03 00 03 3C -> two o_imem_we pulses.
  - First: addr 0x0, data 0x3C010101.
  - Second: addr 0x4, data 0x3C030003.
- Bad load: 0x07, 0x00, then 0x07, 0x41 (65) -> no o_imem_we. A following 0x08 is accepted as a command.
- Continuous: 0x08, 0x0D -> o_cpu_restart pulses once and o_cpu_stall=0. Raise i_halt -> o_cpu_stall=1 on the next edge. A following 0x0A leaves the stall at 1.
- Step: 0x09, 0x0D, then three 0x0A -> exactly three single-cycle o_cpu_stall=0 windows. 0x08 sent while running leaves mode unchanged.
- Dump: regfile model with reg[r]=0x11110000+r, then 0x01 -> 128 bytes, starting 00 00 11 11 01 00 11 11. o_cpu_stall=1 throughout. Bytes sent during the dump are dropped.
- Reset mid-load after 2 payload bytes -> all outputs return to reset values and no write occurs. Under DBG_CMD_ECHO_EN, 0x0D is echoed as 0x0D before o_cpu_restart.
